// File: rtl/gpu_pkg.sv
// Shared definitions for the MiniGPU kernel-launch path.
// Holds the dispatcher and per-core slot state encodings plus the default
// core count, block size and thread-count width used by block_dispatcher.
package gpu_pkg;

  localparam int DEF_NUM_CORES         = 2;
  localparam int DEF_THREADS_PER_BLOCK = 4;
  localparam int DEF_TC_WIDTH          = 8;

  // Top-level dispatcher FSM
  localparam logic [1:0] DISP_IDLE     = 2'd0;
  localparam logic [1:0] DISP_DISPATCH = 2'd1;
  localparam logic [1:0] DISP_COMPLETE = 2'd2;

  // Per-core slot tracker
  localparam logic [1:0] SLOT_FREE    = 2'd0;
  localparam logic [1:0] SLOT_RUN     = 2'd1;
  localparam logic [1:0] SLOT_RECYCLE = 2'd2;

endpackage

// File: rtl/core_slot.sv
// Per-core FREE/RUN/RECYCLE tracker for the block dispatcher.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   assign_i          dispatch this core now (only honoured while FREE)
//   block_id_i        block index to latch on dispatch
//   thread_count_i    active thread count to latch on dispatch
//   core_done_i       core reports block complete (only honoured in RUN)
//   free_o            slot can accept a block this cycle
//   retire_o          a running block completes at the next edge
//   core_start_o      run strobe to the core, high while in RUN
//   core_reset_o      reset to the core, high whenever not in RUN
//   block_id_o        latched block index
//   thread_count_o    latched active thread count
module core_slot
  import gpu_pkg::*;
#(
  parameter int TC_WIDTH = DEF_TC_WIDTH,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                assign_i,
  input  logic [TC_WIDTH-1:0] block_id_i,
  input  logic [CNT_W-1:0]    thread_count_i,
  input  logic                core_done_i,
  output logic                free_o,
  output logic                retire_o,
  output logic                core_start_o,
  output logic                core_reset_o,
  output logic [TC_WIDTH-1:0] block_id_o,
  output logic [CNT_W-1:0]    thread_count_o
);

  logic [1:0]          state_q, state_d;
  logic [TC_WIDTH-1:0] id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      SLOT_FREE: begin
        if (assign_i) begin
          state_d = SLOT_RUN;
          id_d    = block_id_i;
          cnt_d   = thread_count_i;
        end
      end
      SLOT_RUN: begin
        if (core_done_i) state_d = SLOT_RECYCLE;
      end
      // One cycle of core reset before the core may take a new block.
      SLOT_RECYCLE: state_d = SLOT_FREE;
      default:      state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_FREE;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign free_o         = (state_q == SLOT_FREE);
  assign retire_o       = (state_q == SLOT_RUN) && core_done_i;
  assign core_start_o   = (state_q == SLOT_RUN);
  assign core_reset_o   = (state_q != SLOT_RUN);
  assign block_id_o     = id_q;
  assign thread_count_o = cnt_q;

endmodule

// File: rtl/block_dispatcher.sv
// MiniGPU kernel-launch sequencer. Latches the thread count at launch,
// splits it into THREADS_PER_BLOCK-sized blocks and hands one block per
// cycle to the lowest-index free core; raises done once all blocks retire.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start                launch request (level-sampled in IDLE/COMPLETE)
//   thread_count         total kernel threads, sampled only at launch
//   core_done            per-core block-complete flags
//   core_start           per-core run strobe
//   core_reset           per-core reset, high whenever a core is not running
//   core_block_id        per-core block index, core i at [i*TC_WIDTH +: TC_WIDTH]
//   core_thread_count    per-core active threads, log2(TPB)+1 bits each
//   busy                 kernel in progress
//   done                 all blocks retired
module block_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES         = DEF_NUM_CORES,
  parameter int THREADS_PER_BLOCK = DEF_THREADS_PER_BLOCK,
  parameter int TC_WIDTH          = DEF_TC_WIDTH
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [TC_WIDTH-1:0]                                  thread_count,
  input  logic [NUM_CORES-1:0]                                 core_done,
  output logic [NUM_CORES-1:0]                                 core_start,
  output logic [NUM_CORES-1:0]                                 core_reset,
  output logic [NUM_CORES*TC_WIDTH-1:0]                        core_block_id,
  output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]   core_thread_count,
  output logic                                                 busy,
  output logic                                                 done
);

  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int CNT_W    = LOG2_TPB + 1;
  localparam int CW       = TC_WIDTH + 1;

  localparam logic [CW-1:0]    TPB_M1  = CW'(THREADS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] TPB_CNT = CNT_W'(THREADS_PER_BLOCK);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    total_q, total_d;
  logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
  logic [CW-1:0]    disp_q, disp_d;
  logic [CW-1:0]    done_cnt_q, done_cnt_d;

  logic [NUM_CORES-1:0] free_vec, retire_vec, assign_vec;
  logic [CW-1:0]        launch_total, retired;
  logic [CNT_W-1:0]     launch_last, disp_cnt;
  logic                 can_dispatch, found;

  always_comb begin
    // One extra bit keeps tc = 2^TC_WIDTH-1 from wrapping in the round-up.
    launch_total = ({1'b0, thread_count} + TPB_M1) >> LOG2_TPB;
    // Last block holds the remainder; the result never exceeds TPB, so the
    // low CNT_W bits of the difference are exact.
    launch_last  = CNT_W'({1'b0, thread_count} - ((launch_total - 1'b1) << LOG2_TPB));

    retired = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      retired = retired + CW'(retire_vec[i]);
    end

    // Lowest-index free core wins; at most one dispatch per cycle.
    can_dispatch = (state_q == DISP_DISPATCH) && (disp_q < total_q);
    assign_vec   = '0;
    found        = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (free_vec[i] && !found) begin
        assign_vec[i] = can_dispatch;
        found         = 1'b1;
      end
    end
    disp_cnt = (disp_q == total_q - 1'b1) ? last_cnt_q : TPB_CNT;

    state_d    = state_q;
    total_d    = total_q;
    last_cnt_d = last_cnt_q;
    disp_d     = disp_q + CW'(|assign_vec);
    done_cnt_d = done_cnt_q + retired;

    case (state_q)
      DISP_IDLE, DISP_COMPLETE: begin
        if (start) begin
          total_d    = launch_total;
          last_cnt_d = launch_last;
          disp_d     = '0;
          done_cnt_d = '0;
          state_d    = (launch_total == '0) ? DISP_COMPLETE : DISP_DISPATCH;
        end
      end
      DISP_DISPATCH: begin
        if (done_cnt_d == total_q) state_d = DISP_COMPLETE;
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DISP_IDLE;
      total_q    <= '0;
      last_cnt_q <= '0;
      disp_q     <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      last_cnt_q <= last_cnt_d;
      disp_q     <= disp_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    core_slot #(
      .TC_WIDTH (TC_WIDTH),
      .CNT_W    (CNT_W)
    ) u_slot (
      .clk            (clk),
      .reset          (reset),
      .assign_i       (assign_vec[g]),
      .block_id_i     (disp_q[TC_WIDTH-1:0]),
      .thread_count_i (disp_cnt),
      .core_done_i    (core_done[g]),
      .free_o         (free_vec[g]),
      .retire_o       (retire_vec[g]),
      .core_start_o   (core_start[g]),
      .core_reset_o   (core_reset[g]),
      .block_id_o     (core_block_id[g*TC_WIDTH +: TC_WIDTH]),
      .thread_count_o (core_thread_count[g*CNT_W +: CNT_W])
    );
  end

  assign busy = (state_q == DISP_DISPATCH);
  assign done = (state_q == DISP_COMPLETE);

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with default parameters
// (2 cores, 4 threads per block, 8-bit thread count).
module tb_block_dispatcher;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  thread_count;
  logic [1:0]  core_done;
  logic [1:0]  core_start;
  logic [1:0]  core_reset;
  logic [15:0] core_block_id;
  logic [5:0]  core_thread_count;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  block_dispatcher dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    thread_count = 8'd0;
    core_done    = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_start", core_start, 2'b00);
    chk("rst_creset", core_reset, 2'b11);
    chk("rst_id", core_block_id, 16'h0000);
    chk("rst_cnt", core_thread_count, 6'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // tc=8: two full blocks
    start = 1'b1; thread_count = 8'd8;
    tick();
    start = 1'b0;
    chk("t8_busy", busy, 1'b1);
    chk("t8_nostart", core_start, 2'b00);
    tick();
    chk("t8_c0_start", core_start, 2'b01);
    chk("t8_c0_id", core_block_id, 16'h0000);
    chk("t8_c0_cnt", core_thread_count, 6'h04);
    chk("t8_c0_creset", core_reset, 2'b10);
    tick();
    chk("t8_c1_start", core_start, 2'b11);
    chk("t8_c1_id", core_block_id, 16'h0100);
    chk("t8_c1_cnt", core_thread_count, 6'h24);
    chk("t8_notdone", done, 1'b0);
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    chk("t8_done", done, 1'b1);
    chk("t8_busy0", busy, 1'b0);
    chk("t8_idle_start", core_start, 2'b00);
    chk("t8_idle_creset", core_reset, 2'b11);

    // tc=10: three blocks, last has 2 threads; relaunch from COMPLETE
    start = 1'b1; thread_count = 8'd10;
    tick();
    start = 1'b0;
    chk("t10_done_clr", done, 1'b0);
    chk("t10_busy", busy, 1'b1);
    tick();
    tick();
    chk("t10_both", core_start, 2'b11);
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    chk("t10_c1_recyc", core_start, 2'b01);
    chk("t10_c1_creset", core_reset, 2'b10);
    tick();
    chk("t10_c1_free", core_start, 2'b01);
    tick();
    chk("t10_b2_start", core_start, 2'b11);
    chk("t10_b2_id", core_block_id, 16'h0200);
    chk("t10_b2_cnt", core_thread_count, 6'h14);
    core_done = 2'b01;
    tick();
    core_done = 2'b10;
    chk("t10_part", done, 1'b0);
    tick();
    core_done = 2'b00;
    chk("t10_done", done, 1'b1);
    chk("t10_busy0", busy, 1'b0);

    // tc=0 from IDLE: completes immediately with no dispatch
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t0_pre_done", done, 1'b0);
    start = 1'b1; thread_count = 8'd0;
    tick();
    start = 1'b0;
    chk("t0_done", done, 1'b1);
    chk("t0_busy", busy, 1'b0);
    chk("t0_start", core_start, 2'b00);
    tick();
    chk("t0_start2", core_start, 2'b00);
    chk("t0_done2", done, 1'b1);

    // tc=16: simultaneous completion, refill core0 then core1
    start = 1'b1; thread_count = 8'd16;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t16_both", core_start, 2'b11);
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    chk("t16_recyc", core_start, 2'b00);
    chk("t16_busy", busy, 1'b1);
    tick();
    chk("t16_free", core_start, 2'b00);
    tick();
    chk("t16_b2_start", core_start, 2'b01);
    chk("t16_b2_id", core_block_id, 16'h0102);
    tick();
    chk("t16_b3_start", core_start, 2'b11);
    chk("t16_b3_id", core_block_id, 16'h0302);
    chk("t16_b3_cnt", core_thread_count, 6'h24);
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    chk("t16_done", done, 1'b1);

    // Launch protection: start and new thread_count mid-kernel ignored
    start = 1'b1; thread_count = 8'd10;
    tick();
    thread_count = 8'd200;
    tick();
    tick();
    start = 1'b0;
    chk("lp_both", core_start, 2'b11);
    chk("lp_busy", busy, 1'b1);
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    tick();
    tick();
    chk("lp_b2_id", core_block_id, 16'h0102);
    chk("lp_b2_cnt", core_thread_count, 6'h22);
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    chk("lp_done", done, 1'b1);

    // Reset mid-kernel, then a clean tc=4 launch
    start = 1'b1; thread_count = 8'd16;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rm_both", core_start, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_creset", core_reset, 2'b11);
    chk("rm_start", core_start, 2'b00);
    chk("rm_done", done, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_id", core_block_id, 16'h0000);
    chk("rm_cnt", core_thread_count, 6'h00);
    start = 1'b1; thread_count = 8'd4;
    tick();
    start = 1'b0;
    chk("t4_busy", busy, 1'b1);
    tick();
    chk("t4_start", core_start, 2'b01);
    chk("t4_cnt", core_thread_count, 6'h04);
    tick();
    chk("t4_single", core_start, 2'b01);
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    chk("t4_done", done, 1'b1);
    chk("t4_busy0", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
